lvds_frame_scheduler: RTL and testbench
=======================================

LVDS_FRAME_SCHEDULER -- requirements
Module: lvds_frame_scheduler

Interface
REQ-001 The module SHALL have parameter GAP_CYCLES, default 16, giving the number of idle cycles with tx_gate low between frames.
REQ-002 The module SHALL have parameter SYNC_WORD, default 32'h1ACFFC1D, giving the frame sync head, sent MSB byte first.
REQ-003 The module SHALL have port sys_clk, input, 1 bit: single clock for all logic.
REQ-004 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL have ports req0 and req1, input, 1 bit each: frame request per source, held high until the matching grant pulse.
REQ-006 The module SHALL have ports len0 and len1, input, 16 bits each: payload byte count, sampled in the grant cycle.
REQ-007 The module SHALL have ports grant0 and grant1, output, 1 bit each: one-cycle grant pulse.
REQ-008 The module SHALL have ports src_data0 and src_data1, input, 8 bits each: payload byte.
REQ-009 The module SHALL have ports src_valid0 and src_valid1, input, 1 bit each: source byte valid.
REQ-010 The module SHALL have ports src_ready0 and src_ready1, output, 1 bit each: byte accepted from the source.
REQ-011 The module SHALL have port tx_data, output, 8 bits: byte to the LVDS serializer.
REQ-012 The module SHALL have port tx_valid, output, 1 bit, and port tx_ready, input, 1 bit: byte handshake with the serializer.
REQ-013 The module SHALL have port tx_gate, output, 1 bit: frame envelope, high from the first sync byte through the last payload byte.
REQ-014 The module SHALL have ports tx_sof and tx_eof, output, 1 bit each: qualify the first sync byte and the last frame byte.
REQ-015 The module SHALL have ports frame_done, output, 1 bit; frame_src, output, 1 bit; and busy, output, 1 bit: completion pulse, source id of that frame, and scheduler not idle.

Function
REQ-016 The state machine SHALL have states IDLE, SYNC, PAYLOAD and GAP.
REQ-017 A byte transfer SHALL occur only in a cycle where tx_valid and tx_ready are both high; tx_data SHALL remain stable while tx_valid is high and tx_ready is low.
REQ-018 In IDLE, when any request is high, the scheduler SHALL grant exactly one source by round-robin: the source not most recently granted wins a tie, and after reset source 0 wins a tie.
REQ-019 In the grant cycle, the scheduler SHALL latch the granted source's length and move to SYNC on the next cycle.
REQ-020 In SYNC, the scheduler SHALL send the four SYNC_WORD bytes (1A, CF, FC, 1D at defaults), with tx_gate high and tx_sof high on the first byte.
REQ-021 In PAYLOAD, src_ready of the granted source SHALL equal tx_ready, tx_valid SHALL equal that source's src_valid, and tx_data SHALL equal that source's src_data (combinational pass-through).
REQ-022 The src_ready of the non-granted source SHALL be held low at all times.
REQ-023 A source stall (src_valid low) SHALL hold tx_gate high and SHALL NOT advance the byte counter.
REQ-024 The 16-bit byte counter SHALL count payload transfers; the transfer with count equal to len-1 SHALL carry tx_eof, then frame_done SHALL pulse for one cycle with frame_src set, and the state SHALL move to GAP.
REQ-025 When len is 0, the frame SHALL consist of sync only: tx_eof on sync byte 4, PAYLOAD skipped.
REQ-026 When len is 65535, the frame SHALL complete with no counter wrap.
REQ-027 In GAP, tx_gate and tx_valid SHALL be low for exactly GAP_CYCLES cycles, after which the state SHALL return to IDLE; requests arriving during SYNC, PAYLOAD or GAP SHALL wait.
REQ-028 busy SHALL be high in every state except IDLE.

Reset
REQ-029 While rst_n is low at a sys_clk edge, the scheduler SHALL enter IDLE, and every output SHALL read 0 (tx_data 8'h00).
REQ-030 Reset SHALL set the round-robin pointer to favour source 0 and clear the counters.
REQ-031 Reset mid-frame SHALL abort the frame immediately, with no tx_eof and no frame_done.

Structure
REQ-032 Package lvds_pkg SHALL hold the state enum, the default SYNC_WORD constant and the 16-bit length type.
REQ-033 Arbitration SHALL be implemented in one sub-module, lvds_rr_arb2: inputs req[1:0] and enable, outputs a one-hot grant, with the pointer updated on grant.

Verification
REQ-034 Single frame: req0 with len0=4, source always valid, tx_ready=1 -> tx_data 1A CF FC 1D d0..d3; gate high for 8 transfers; one frame_done with frame_src=0; gate low for 16 cycles.
REQ-035 Contention: req0 and req1 both high continuously -> grants alternate 0,1,0,1, each frame is separated by a 16-cycle gap, and src_ready of the idle source is never high.
REQ-036 Backpressure: tx_ready toggled 1-0 and src_valid1 randomly low during a len1=896 frame -> exactly 900 transfers, no duplicated or dropped bytes, tx_eof on transfer 900.
REQ-037 Zero length: len0=0 -> 4-byte frame with tx_sof on byte 1, tx_eof on byte 4, and frame_done pulses.
REQ-038 Mid-frame reset: rst_n low for 1 cycle at payload byte 10 -> all outputs 0 on the next cycle, no frame_done; the next tie is won by source 0.

Source files
------------

// File: rtl/lvds_pkg.sv
// Shared types and constants for the LVDS frame scheduler: FSM states,
// payload length type and the default sync head.
package lvds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_GAP
  } lvds_state_e;

  typedef logic [15:0] lvds_len_t;

  localparam logic [31:0] LVDS_SYNC_WORD = 32'h1ACFFC1D;

  // Sync head goes out MSB byte first.
  function automatic logic [7:0] sync_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lvds_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant while enabled,
// priority flips to the other source whenever a grant is issued.
module lvds_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  // prio_q = index of the source that wins a tie
  logic prio_q;

  always_comb begin
    grant = '0;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (grant[0]) begin
      prio_q <= 1'b1;
    end else if (grant[1]) begin
      prio_q <= 1'b0;
    end
  end

endmodule

// File: rtl/lvds_frame_scheduler.sv
// Frame scheduler for an LVDS serializer: arbitrates two sources, emits
// sync head + payload per frame, then holds an idle gap before the next one.
module lvds_frame_scheduler
  import lvds_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [31:0] SYNC_WORD  = LVDS_SYNC_WORD
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] len0,
  input  logic [15:0] len1,
  output logic        grant0,
  output logic        grant1,
  input  logic [7:0]  src_data0,
  input  logic [7:0]  src_data1,
  input  logic        src_valid0,
  input  logic        src_valid1,
  output logic        src_ready0,
  output logic        src_ready1,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_gate,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        frame_done,
  output logic        frame_src,
  output logic        busy
);

  localparam lvds_len_t GAP_LAST = lvds_len_t'(GAP_CYCLES - 1);

  lvds_state_e state_q, state_d;
  lvds_len_t   len_q;
  lvds_len_t   cnt_q;
  lvds_len_t   len_last;
  logic [1:0]  sync_idx_q;
  logic        src_q;
  logic        done_q;
  logic        done_src_q;
  logic        arb_en;
  logic [1:0]  arb_grant;
  logic        last;
  logic        done_set;

  lvds_rr_arb2 u_arb (
    .clk    (sys_clk),
    .rst_n  (rst_n),
    .req    ({req1, req0}),
    .enable (arb_en),
    .grant  (arb_grant)
  );

  assign len_last   = len_q - 16'd1;
  assign grant0     = arb_grant[0];
  assign grant1     = arb_grant[1];
  assign frame_done = done_q;
  assign frame_src  = done_src_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    arb_en     = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    tx_gate    = 1'b0;
    tx_sof     = 1'b0;
    tx_eof     = 1'b0;
    src_ready0 = 1'b0;
    src_ready1 = 1'b0;
    last       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Grant is gated by rst_n so every output reads 0 during reset.
        arb_en = rst_n;
        if (|arb_grant) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        tx_valid = 1'b1;
        tx_gate  = 1'b1;
        tx_data  = sync_byte(SYNC_WORD, sync_idx_q);
        tx_sof   = (sync_idx_q == 2'd0);
        last     = (sync_idx_q == 2'd3) && (len_q == '0);
        tx_eof   = last;
        if (tx_ready && sync_idx_q == 2'd3) begin
          state_d = (len_q == '0) ? ST_GAP : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        tx_gate    = 1'b1;
        tx_valid   = src_q ? src_valid1 : src_valid0;
        tx_data    = src_q ? src_data1 : src_data0;
        src_ready0 = !src_q && tx_ready;
        src_ready1 = src_q && tx_ready;
        last       = (cnt_q == len_last);
        tx_eof     = last;
        if (tx_valid && tx_ready && last) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_set = tx_valid && tx_ready && last;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      sync_idx_q <= '0;
      src_q      <= 1'b0;
      done_q     <= 1'b0;
      done_src_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_set;
      if (done_set) done_src_q <= src_q;
      case (state_q)
        ST_IDLE: begin
          if (|arb_grant) begin
            len_q      <= arb_grant[1] ? len1 : len0;
            src_q      <= arb_grant[1];
            sync_idx_q <= '0;
            cnt_q      <= '0;
          end
        end
        ST_SYNC: begin
          if (tx_ready) begin
            sync_idx_q <= sync_idx_q + 2'd1;
            cnt_q      <= '0;
          end
        end
        ST_PAYLOAD: begin
          // Counter is reused as the gap timer, so clear it on the final byte.
          if (tx_valid && tx_ready) cnt_q <= last ? '0 : cnt_q + 16'd1;
        end
        ST_GAP: begin
          cnt_q <= cnt_q + 16'd1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_frame_scheduler.sv
// Directed bench for lvds_frame_scheduler: single frame, contention,
// backpressure, zero length and mid-frame reset.
module tb_lvds_frame_scheduler;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] len0, len1;
  logic        grant0, grant1;
  logic [7:0]  src_data0, src_data1;
  logic        src_valid0, src_valid1;
  logic        src_ready0, src_ready1;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_gate, tx_sof, tx_eof;
  logic        frame_done, frame_src, busy;

  always #5 sys_clk = ~sys_clk;

  lvds_frame_scheduler #(.GAP_CYCLES(16), .SYNC_WORD(32'h1ACFFC1D)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .grant0(grant0), .grant1(grant1),
    .src_data0(src_data0), .src_data1(src_data1),
    .src_valid0(src_valid0), .src_valid1(src_valid1),
    .src_ready0(src_ready0), .src_ready1(src_ready1),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_gate(tx_gate), .tx_sof(tx_sof), .tx_eof(tx_eof),
    .frame_done(frame_done), .frame_src(frame_src), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] cap_data[$];
  bit         cap_sof[$];
  bit         cap_eof[$];
  int         grants[$];
  int         done_src[$];
  int         gaps[$];

  int  src_idx0, src_idx1, cur_src, gap_run;
  int  bad_rdy, gate_viol, stab_viol;
  bit  keep_req, toggle_ready, rand_valid1, in_frame, prev_stall;
  logic [7:0]  prev_data;
  logic [18:0] outs_snap;
  logic [7:0]  sync_b[4] = '{8'h1A, 8'hCF, 8'hFC, 8'h1D};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int s, input int k);
    return 8'(k * 5 + s * 64 + 3);
  endfunction

  // One clock: observe mid-cycle, then update the source/sink models after the edge.
  task automatic tick();
    bit g0, g1, hs0, hs1;
    @(negedge sys_clk);
    outs_snap = {grant0, grant1, src_ready0, src_ready1, tx_data, tx_valid,
                 tx_gate, tx_sof, tx_eof, frame_done, frame_src, busy};
    g0 = grant0; g1 = grant1;
    if (g0) grants.push_back(0);
    if (g1) grants.push_back(1);
    hs0 = src_ready0 && src_valid0;
    hs1 = src_ready1 && src_valid1;
    if ((src_ready0 && cur_src != 0) || (src_ready1 && cur_src != 1)) bad_rdy++;
    if (tx_valid && !tx_gate) gate_viol++;
    if (in_frame && !tx_gate) gate_viol++;
    if (prev_stall && tx_valid && tx_data !== prev_data) stab_viol++;
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    if (tx_valid && tx_ready) begin
      cap_data.push_back(tx_data);
      cap_sof.push_back(tx_sof);
      cap_eof.push_back(tx_eof);
      if (tx_sof) in_frame = 1'b1;
      if (tx_eof) in_frame = 1'b0;
    end
    if (frame_done) done_src.push_back(int'(frame_src));
    if (busy && !tx_gate) gap_run++;
    else if (gap_run > 0) begin
      gaps.push_back(gap_run);
      gap_run = 0;
    end
    @(posedge sys_clk); #1;
    if (g0) begin cur_src = 0; src_idx0 = 0; if (!keep_req) req0 = 1'b0; end
    else if (hs0) src_idx0++;
    if (g1) begin cur_src = 1; src_idx1 = 0; if (!keep_req) req1 = 1'b0; end
    else if (hs1) src_idx1++;
    src_data0  = pat(0, src_idx0);
    src_data1  = pat(1, src_idx1);
    src_valid0 = 1'b1;
    src_valid1 = rand_valid1 ? ($urandom_range(0, 3) != 0) : 1'b1;
    tx_ready   = toggle_ready ? !tx_ready : 1'b1;
  endtask

  task automatic clear_logs();
    cap_data.delete(); cap_sof.delete(); cap_eof.delete();
    grants.delete(); done_src.delete(); gaps.delete();
    bad_rdy = 0; gate_viol = 0; stab_viol = 0; gap_run = 0;
    in_frame = 1'b0; prev_stall = 1'b0; cur_src = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    keep_req = 1'b0; toggle_ready = 1'b0; rand_valid1 = 1'b0; tx_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic run_until_gaps(input string tag, input int n, input int budget);
    int c = 0;
    while (gaps.size() < n && c < budget) begin
      tick();
      c++;
    end
    check_eq({tag, "_complete"}, 32'(gaps.size() >= n), 32'd1);
  endtask

  function automatic int count_eof();
    int e = 0;
    foreach (cap_eof[i]) if (cap_eof[i]) e++;
    return e;
  endfunction

  initial begin
    int errs, nb, lastg, c;
    logic [7:0] exp_b;

    // Reset with a request pending: grant must stay low too.
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; len0 = 16'd4; len1 = 16'd0;
    src_data0 = '0; src_data1 = '0; src_valid0 = 1'b1; src_valid1 = 1'b1;
    tx_ready = 1'b1; keep_req = 1'b0; toggle_ready = 1'b0; rand_valid1 = 1'b0;
    src_idx0 = 0; src_idx1 = 0;
    clear_logs();
    tick(); tick(); tick();
    check_eq("reset_outputs", 32'(outs_snap), 32'd0);
    rst_n = 1'b1;
    clear_logs();

    // Single frame, len 4
    run_until_gaps("single", 1, 200);
    check_eq("single_count", cap_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 4) ? sync_b[i] : pat(0, i - 4);
      if (i < cap_data.size()) check_eq($sformatf("single_byte%0d", i), cap_data[i], exp_b);
    end
    if (cap_data.size() == 8) begin
      check_eq("single_sof", cap_sof[0], 1);
      check_eq("single_eof_last", cap_eof[7], 1);
    end
    check_eq("single_eof_count", count_eof(), 1);
    check_eq("single_grants", grants.size(), 1);
    check_eq("single_done", done_src.size(), 1);
    if (done_src.size() > 0) check_eq("single_frame_src", done_src[0], 0);
    if (gaps.size() > 0) check_eq("single_gap", gaps[0], 16);
    check_eq("single_gate", gate_viol, 0);

    // Contention, both requests held high
    do_reset();
    len0 = 16'd3; len1 = 16'd2; keep_req = 1'b1; req0 = 1'b1; req1 = 1'b1;
    run_until_gaps("cont", 4, 600);
    check_eq("cont_grants_n", 32'(grants.size() >= 4), 1);
    if (grants.size() >= 4) begin
      check_eq("cont_grant0", grants[0], 0);
      check_eq("cont_grant1", grants[1], 1);
      check_eq("cont_grant2", grants[2], 0);
      check_eq("cont_grant3", grants[3], 1);
    end
    check_eq("cont_done_n", done_src.size(), 4);
    if (done_src.size() == 4) begin
      check_eq("cont_src0", done_src[0], 0);
      check_eq("cont_src1", done_src[1], 1);
    end
    if (gaps.size() >= 4) begin
      check_eq("cont_gap0", gaps[0], 16);
      check_eq("cont_gap3", gaps[3], 16);
    end
    check_eq("cont_xfers", 32'(cap_data.size() >= 26), 1);
    if (cap_data.size() >= 26) begin
      check_eq("cont_f0_byte0", cap_data[4], pat(0, 0));
      check_eq("cont_f1_byte1", cap_data[12], pat(1, 1));
    end
    check_eq("cont_idle_ready", bad_rdy, 0);

    // Backpressure: tx_ready toggling, source 1 randomly stalling
    do_reset();
    len1 = 16'd896; req1 = 1'b1; toggle_ready = 1'b1; rand_valid1 = 1'b1;
    run_until_gaps("bp", 1, 20000);
    check_eq("bp_count", cap_data.size(), 900);
    errs = 0;
    foreach (cap_data[k]) begin
      exp_b = (k < 4) ? sync_b[k] : pat(1, k - 4);
      if (cap_data[k] !== exp_b) errs++;
    end
    check_eq("bp_bytes", errs, 0);
    check_eq("bp_eof_count", count_eof(), 1);
    if (cap_data.size() == 900) begin
      check_eq("bp_eof_900", cap_eof[899], 1);
      check_eq("bp_sof_1", cap_sof[0], 1);
    end
    check_eq("bp_stable", stab_viol, 0);
    check_eq("bp_gate", gate_viol, 0);
    check_eq("bp_idle_ready", bad_rdy, 0);
    if (done_src.size() > 0) check_eq("bp_frame_src", done_src[0], 1);

    // Zero-length frame
    do_reset();
    len0 = 16'd0; req0 = 1'b1;
    run_until_gaps("zero", 1, 200);
    check_eq("zero_count", cap_data.size(), 4);
    if (cap_data.size() == 4) begin
      check_eq("zero_sof", cap_sof[0], 1);
      check_eq("zero_eof", cap_eof[3], 1);
      check_eq("zero_byte3", cap_data[3], 8'h1D);
    end
    check_eq("zero_eof_count", count_eof(), 1);
    check_eq("zero_done", done_src.size(), 1);
    if (gaps.size() > 0) check_eq("zero_gap", gaps[0], 16);

    // Mid-frame reset at payload byte 10
    do_reset();
    len0 = 16'd20; req0 = 1'b1;
    c = 0;
    while (cap_data.size() < 14 && c < 100) begin tick(); c++; end
    check_eq("mid_reached", 32'(cap_data.size() >= 14), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_frame = 1'b0;
    tick();
    check_eq("mid_rst_outputs", 32'(outs_snap), 32'd0);
    for (int i = 0; i < 30; i++) tick();
    check_eq("mid_no_done", done_src.size(), 0);
    check_eq("mid_no_eof", count_eof(), 0);
    nb = grants.size();
    req0 = 1'b1; req1 = 1'b1;
    c = 0;
    while (grants.size() <= nb && c < 10) begin tick(); c++; end
    lastg = (grants.size() > nb) ? grants[nb] : -1;
    check_eq("mid_tie_src0", lastg, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
